// File: rtl/mem_stage_lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_stage_lsu
// Description : Memory-stage load/store unit: lane steering, sign extension,
//               misalignment detection and a bounded req/ack memory handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_lsu #(
    parameter int MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] ALUResultIn,
    input  logic [31:0] MemDataIn,
    input  logic        MemReadIn,
    input  logic        MemWriteIn,
    input  logic [1:0]  dataTypeIn,
    input  logic        RegWriteIn,
    input  logic        MemToRegIn,
    input  logic [4:0]  rdRegIn,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        Stall,
    output logic [31:0] LoadDataOut,
    output logic [31:0] ALUResultOut,
    output logic [4:0]  rdRegOut,
    output logic        RegWriteOut,
    output logic        MemToRegOut,
    output logic        MisalignOut,
    output logic        TimeoutOut
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] SZ_WORD = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_BYTE = 2'b10;
    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        we_q, we_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        timeout_q, timeout_d;
    logic        rw_lat_q, rw_lat_d;
    logic        m2r_lat_q, m2r_lat_d;
    logic [4:0]  rd_lat_q, rd_lat_d;

    logic [31:0] alu_out_q, alu_out_d;
    logic [4:0]  rd_out_q, rd_out_d;
    logic        rw_out_q, rw_out_d;
    logic        m2r_out_q, m2r_out_d;
    logic [31:0] load_out_q, load_out_d;
    logic        mis_out_q, mis_out_d;
    logic        to_out_q, to_out_d;

    logic        access;
    logic [1:0]  size_in;
    logic        misaligned;
    logic [3:0]  be_in;
    logic [31:0] wdata_in;
    logic [7:0]  byte_lane;
    logic [15:0] half_lane;
    logic [31:0] load_ext;
    logic        stall_int;

    // Reserved size code behaves exactly like a word access.
    always_comb begin
        access     = MemReadIn | MemWriteIn;
        size_in    = (dataTypeIn == 2'b11) ? SZ_WORD : dataTypeIn;
        misaligned = 1'b0;
        be_in      = 4'b1111;
        wdata_in   = MemDataIn;
        case (size_in)
            SZ_BYTE: begin
                be_in    = 4'b0001 << ALUResultIn[1:0];
                wdata_in = {4{MemDataIn[7:0]}};
            end
            SZ_HALF: begin
                misaligned = ALUResultIn[0];
                be_in      = ALUResultIn[1] ? 4'b1100 : 4'b0011;
                wdata_in   = {2{MemDataIn[15:0]}};
            end
            default: misaligned = (ALUResultIn[1:0] != 2'b00);
        endcase
    end

    always_comb begin
        byte_lane = rdata_q[{addr_q[1:0], 3'b000} +: 8];
        half_lane = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (size_q)
            SZ_BYTE: load_ext = {{24{byte_lane[7]}}, byte_lane};
            SZ_HALF: load_ext = {{16{half_lane[15]}}, half_lane};
            default: load_ext = rdata_q;
        endcase
    end

    // Output register fields are only assigned on non-stalling paths, so they
    // hold by default whenever the pipeline is stalled.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        size_d     = size_q;
        we_d       = we_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        timeout_d  = timeout_q;
        rw_lat_d   = rw_lat_q;
        m2r_lat_d  = m2r_lat_q;
        rd_lat_d   = rd_lat_q;
        alu_out_d  = alu_out_q;
        rd_out_d   = rd_out_q;
        rw_out_d   = rw_out_q;
        m2r_out_d  = m2r_out_q;
        load_out_d = load_out_q;
        mis_out_d  = mis_out_q;
        to_out_d   = to_out_q;
        stall_int  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d     = 8'd0;
                timeout_d = 1'b0;
                if (access && !misaligned) begin
                    stall_int = 1'b1;
                    addr_d    = ALUResultIn;
                    size_d    = size_in;
                    we_d      = MemWriteIn;
                    be_d      = be_in;
                    wdata_d   = wdata_in;
                    rw_lat_d  = RegWriteIn;
                    m2r_lat_d = MemToRegIn;
                    rd_lat_d  = rdRegIn;
                    state_d   = REQ;
                end else begin
                    alu_out_d  = ALUResultIn;
                    rd_out_d   = rdRegIn;
                    rw_out_d   = RegWriteIn & ~access;
                    m2r_out_d  = MemToRegIn;
                    load_out_d = 32'd0;
                    mis_out_d  = access;
                    to_out_d   = 1'b0;
                end
            end
            REQ: begin
                stall_int = 1'b1;
                if (mem_ack) begin
                    rdata_d = mem_rdata;
                    state_d = DONE;
                end else if (cnt_q == LAST_WAIT) begin
                    timeout_d = 1'b1;
                    state_d   = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            DONE: begin
                alu_out_d  = addr_q;
                rd_out_d   = rd_lat_q;
                rw_out_d   = rw_lat_q & ~timeout_q;
                m2r_out_d  = m2r_lat_q;
                load_out_d = (timeout_q || we_q) ? 32'd0 : load_ext;
                mis_out_d  = 1'b0;
                to_out_d   = timeout_q;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            addr_q     <= 32'd0;
            size_q     <= SZ_WORD;
            we_q       <= 1'b0;
            be_q       <= 4'd0;
            wdata_q    <= 32'd0;
            rdata_q    <= 32'd0;
            timeout_q  <= 1'b0;
            rw_lat_q   <= 1'b0;
            m2r_lat_q  <= 1'b0;
            rd_lat_q   <= 5'd0;
            alu_out_q  <= 32'd0;
            rd_out_q   <= 5'd0;
            rw_out_q   <= 1'b0;
            m2r_out_q  <= 1'b0;
            load_out_q <= 32'd0;
            mis_out_q  <= 1'b0;
            to_out_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            size_q     <= size_d;
            we_q       <= we_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            timeout_q  <= timeout_d;
            rw_lat_q   <= rw_lat_d;
            m2r_lat_q  <= m2r_lat_d;
            rd_lat_q   <= rd_lat_d;
            alu_out_q  <= alu_out_d;
            rd_out_q   <= rd_out_d;
            rw_out_q   <= rw_out_d;
            m2r_out_q  <= m2r_out_d;
            load_out_q <= load_out_d;
            mis_out_q  <= mis_out_d;
            to_out_q   <= to_out_d;
        end
    end

    // Stall is forced low while reset is asserted, regardless of inputs.
    assign Stall        = rst_n & stall_int;
    assign mem_req      = (state_q == REQ);
    assign mem_we       = mem_req & we_q;
    assign mem_be       = mem_req ? be_q : 4'd0;
    assign mem_addr     = {addr_q[31:2], 2'b00};
    assign mem_wdata    = wdata_q;
    assign LoadDataOut  = load_out_q;
    assign ALUResultOut = alu_out_q;
    assign rdRegOut     = rd_out_q;
    assign RegWriteOut  = rw_out_q;
    assign MemToRegOut  = m2r_out_q;
    assign MisalignOut  = mis_out_q;
    assign TimeoutOut   = to_out_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_lsu
// Description : Scoreboard bench for mem_stage_lsu with a randomized memory
//               responder and a spec-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_lsu;

    localparam int MAX_WAIT = 16;
    localparam int NEVER    = 255;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] ALUResultIn = '0, MemDataIn = '0;
    logic        MemReadIn = 1'b0, MemWriteIn = 1'b0;
    logic [1:0]  dataTypeIn = '0;
    logic        RegWriteIn = 1'b0, MemToRegIn = 1'b0;
    logic [4:0]  rdRegIn = '0;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;
    logic        Stall;
    logic [31:0] LoadDataOut, ALUResultOut;
    logic [4:0]  rdRegOut;
    logic        RegWriteOut, MemToRegOut, MisalignOut, TimeoutOut;

    always #5 clk = ~clk;

    mem_stage_lsu #(.MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst_n(rst_n),
        .ALUResultIn(ALUResultIn), .MemDataIn(MemDataIn),
        .MemReadIn(MemReadIn), .MemWriteIn(MemWriteIn), .dataTypeIn(dataTypeIn),
        .RegWriteIn(RegWriteIn), .MemToRegIn(MemToRegIn), .rdRegIn(rdRegIn),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .Stall(Stall), .LoadDataOut(LoadDataOut), .ALUResultOut(ALUResultOut),
        .rdRegOut(rdRegOut), .RegWriteOut(RegWriteOut), .MemToRegOut(MemToRegOut),
        .MisalignOut(MisalignOut), .TimeoutOut(TimeoutOut)
    );

    typedef struct packed {
        logic [31:0] alu;
        logic [4:0]  rd;
        logic        rw;
        logic        m2r;
        logic [31:0] ld;
        logic        mis;
        logic        to;
    } res_t;

    typedef struct {
        int          d;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic [3:0]  be;
        logic        we;
        logic [31:0] wdata;
    } mreq_t;

    res_t  out_q[$];
    mreq_t mem_q[$];
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Result monitor: one result per rising edge with Stall low.
    initial begin : monitor
        bit   ok;
        res_t act, exp;
        forever begin
            @(negedge clk);
            ok = rst_n && !Stall && mon_en;
            @(posedge clk);
            #1;
            if (ok && rst_n) begin
                act = {ALUResultOut, rdRegOut, RegWriteOut, MemToRegOut,
                       LoadDataOut, MisalignOut, TimeoutOut};
                checks++;
                if (out_q.size() == 0) begin
                    errors++;
                    $display("FAIL result: unexpected output alu=%h", ALUResultOut);
                end else begin
                    exp = out_q.pop_front();
                    if (act !== exp) begin
                        errors++;
                        $display("FAIL result: got alu=%h rd=%0d rw=%b m2r=%b ld=%h mis=%b to=%b expected alu=%h rd=%0d rw=%b m2r=%b ld=%h mis=%b to=%b",
                                 act.alu, act.rd, act.rw, act.m2r, act.ld, act.mis, act.to,
                                 exp.alu, exp.rd, exp.rw, exp.m2r, exp.ld, exp.mis, exp.to);
                    end
                end
            end
        end
    end

    // Memory responder: checks request fields, acks after the planned delay,
    // and throws spurious acks while no request is active.
    initial begin : responder
        mreq_t cur;
        int    cnt;
        int    exp_len;
        bit    inreq;
        cnt = 0;
        inreq = 1'b0;
        cur = '{d: NEVER, rdata: 32'd0, addr: 32'd0, be: 4'd0, we: 1'b0, wdata: 32'd0};
        mem_ack = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                inreq = 1'b0;
                mem_ack = 1'b0;
            end else if (mem_req) begin
                if (!inreq) begin
                    inreq = 1'b1;
                    cnt = 0;
                    if (mem_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL mem_req: unexpected request addr=%h", mem_addr);
                        cur = '{d: NEVER, rdata: 32'd0, addr: 32'd0, be: 4'd0, we: 1'b0, wdata: 32'd0};
                    end else begin
                        cur = mem_q.pop_front();
                    end
                end
                checks++;
                if ({mem_addr, mem_be, mem_we, mem_wdata} !== {cur.addr, cur.be, cur.we, cur.wdata}) begin
                    errors++;
                    $display("FAIL mem_fields: got addr=%h be=%b we=%b wdata=%h expected addr=%h be=%b we=%b wdata=%h",
                             mem_addr, mem_be, mem_we, mem_wdata, cur.addr, cur.be, cur.we, cur.wdata);
                end
                mem_ack = (cnt == cur.d);
                mem_rdata = mem_ack ? cur.rdata : $urandom;
                cnt++;
            end else begin
                if (inreq) begin
                    exp_len = (cur.d < MAX_WAIT) ? cur.d + 1 : MAX_WAIT;
                    check("req_cycles", 32'(cnt), 32'(exp_len));
                    inreq = 1'b0;
                end
                mem_ack = ($urandom_range(0, 5) == 0);
                mem_rdata = $urandom;
            end
        end
    end

    // Drive one instruction, record its expected result and memory request,
    // and hold it until the edge that consumes it.
    task automatic issue(input logic rd, input logic wr, input logic [1:0] dt,
                         input logic [31:0] alu, input logic [31:0] data,
                         input logic rw, input logic m2r, input logic [4:0] rdr,
                         input int d, input logic [31:0] rdata);
        logic        acc, aligned, to;
        logic [1:0]  off;
        logic [31:0] lane, ld;
        int          sz, stalls, exp_stalls;
        res_t        e;
        mreq_t       m;
        MemReadIn = rd; MemWriteIn = wr; dataTypeIn = dt; ALUResultIn = alu;
        MemDataIn = data; RegWriteIn = rw; MemToRegIn = m2r; rdRegIn = rdr;
        acc = rd | wr;
        off = alu[1:0];
        sz = (dt == 2'b10) ? 1 : (dt == 2'b01) ? 2 : 4;
        aligned = ((alu % sz) == 0);
        to = (d >= MAX_WAIT);
        lane = rdata >> (8 * off);
        if (sz == 1)      ld = lane[7]  ? (lane | 32'hFFFFFF00) : (lane & 32'h000000FF);
        else if (sz == 2) ld = lane[15] ? (lane | 32'hFFFF0000) : (lane & 32'h0000FFFF);
        else              ld = rdata;
        e.alu = alu; e.rd = rdr; e.m2r = m2r;
        e.mis = acc && !aligned;
        e.to  = acc && aligned && to;
        e.rw  = rw && !e.mis && !e.to;
        e.ld  = (acc && aligned && !wr && !to) ? ld : 32'd0;
        out_q.push_back(e);
        exp_stalls = 0;
        if (acc && aligned) begin
            m.d = d; m.rdata = rdata; m.addr = alu - 32'(off); m.we = wr;
            m.be = 4'(((1 << sz) - 1) << off);
            m.wdata = (sz == 1) ? 32'(data[7:0]) * 32'h01010101 :
                      (sz == 2) ? 32'(data[15:0]) * 32'h00010001 : data;
            mem_q.push_back(m);
            exp_stalls = 1 + (to ? MAX_WAIT : d + 1);
        end
        stalls = 0;
        forever begin
            @(negedge clk);
            if (!Stall) break;
            stalls++;
            if (stalls > MAX_WAIT + 4) begin
                $display("FAIL stall_bound: stalled %0d cycles expected %0d", stalls, exp_stalls);
                $fatal(1, "stall bound exceeded");
            end
        end
        check("stall_cycles", 32'(stalls), 32'(exp_stalls));
        @(posedge clk);
        #1;
    endtask

    task automatic nop_inputs();
        MemReadIn = 1'b0; MemWriteIn = 1'b0; dataTypeIn = 2'b00; ALUResultIn = 32'd0;
        MemDataIn = 32'd0; RegWriteIn = 1'b0; MemToRegIn = 1'b0; rdRegIn = 5'd0;
    endtask

    initial begin : driver
        int  k, d, r;
        bit  seen;
        logic [31:0] a;
        nop_inputs();
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_mem_be", mem_be, 0);
        check("rst_stall", Stall, 0);
        check("rst_alu_out", ALUResultOut, 0);
        check("rst_rw_out", RegWriteOut, 0);
        check("rst_ld_out", LoadDataOut, 0);
        check("rst_flags", {MisalignOut, TimeoutOut, MemToRegOut, rdRegOut}, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        mon_en = 1'b1;
        @(posedge clk);
        #1;

        issue(0, 0, 2'b00, 32'h1234, 32'h0, 1, 0, 5'd5, 0, 32'h0);
        issue(0, 1, 2'b10, 32'h103, 32'h000000AB, 0, 0, 5'd0, 1, 32'h0);
        issue(1, 0, 2'b01, 32'h202, 32'h0, 1, 1, 5'd3, 0, 32'h80017FFF);
        issue(1, 0, 2'b10, 32'h200, 32'h0, 1, 1, 5'd4, 0, 32'h80017FFF);
        issue(1, 0, 2'b00, 32'h200, 32'h0, 1, 1, 5'd6, 0, 32'h80017FFF);
        issue(1, 0, 2'b00, 32'h006, 32'h0, 1, 1, 5'd7, 0, 32'h0);
        issue(0, 0, 2'b00, 32'h55, 32'h0, 1, 0, 5'd8, 0, 32'h0);
        issue(1, 0, 2'b00, 32'h40, 32'h0, 1, 1, 5'd9, NEVER, 32'h0);
        issue(1, 0, 2'b11, 32'h44, 32'h0, 1, 1, 5'd10, MAX_WAIT - 1, 32'h12345678);
        issue(1, 1, 2'b01, 32'h86, 32'hBEEF1234, 1, 0, 5'd11, 0, 32'hFFFFFFFF);
        issue(0, 0, 2'b00, 32'h99, 32'h0, 1, 0, 5'd12, 0, 32'h0);

        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 3);
            a = $urandom;
            if ($urandom_range(0, 2) != 0) a[1:0] = 2'b00;
            r = $urandom_range(0, 9);
            if (r < 7)       d = $urandom_range(0, 3);
            else if (r == 7) d = MAX_WAIT - 1;
            else if (r == 8) d = NEVER;
            else             d = $urandom_range(0, MAX_WAIT - 1);
            issue(k == 1 || k == 3, k >= 2, 2'($urandom), a, $urandom,
                  1'($urandom), 1'($urandom), 5'($urandom), d, $urandom);
        end

        // Reset in the third cycle of an outstanding request.
        MemReadIn = 1'b1; MemWriteIn = 1'b0; dataTypeIn = 2'b00; ALUResultIn = 32'h300;
        MemDataIn = 32'd0; RegWriteIn = 1'b1; MemToRegIn = 1'b1; rdRegIn = 5'd13;
        mem_q.push_back('{d: NEVER, rdata: 32'd0, addr: 32'h300, be: 4'hF, we: 1'b0, wdata: 32'd0});
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = mem_req;
        end
        check("rst_test_req_seen", seen, 1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_mem_req", mem_req, 0);
        check("midrst_stall", Stall, 0);
        check("midrst_mem_be", {mem_be, mem_we}, 0);
        check("midrst_outputs", {ALUResultOut[15:0], rdRegOut, RegWriteOut, MisalignOut, TimeoutOut}, 0);
        out_q.delete();
        mem_q.delete();
        nop_inputs();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        issue(1, 0, 2'b00, 32'h300, 32'h0, 1, 1, 5'd13, 0, 32'hCAFEF00D);
        issue(0, 0, 2'b00, 32'h77, 32'h0, 1, 0, 5'd14, 0, 32'h0);

        #1 mon_en = 1'b0;
        check("queues_drained", 32'(out_q.size() + mem_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Memory-stage load/store unit. It consumes the EX/MEM pipeline register outputs and drives a req/ack data-memory port.
- It produces MEM/WB-bound registered results.
- It performs byte/half/word lane steering, sign extension and misalignment detection.
- It holds the pipeline with Stall while a memory transaction is outstanding, and aborts on a bounded-wait timeout.

Parameters:
- MAX_WAIT, 16, maximum REQ cycles without mem_ack before abort (range 1..255).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ALUResultIn  in  32  effective address, or ALU result for non-memory instructions.
- MemDataIn  in  32  store data.
- MemReadIn  in  1  load request.
- MemWriteIn  in  1  store request.
- dataTypeIn  in  2  access size: 00 word, 01 half, 10 byte, 11 reserved (treated as word).
- RegWriteIn  in  1  writeback enable.
- MemToRegIn  in  1  writeback select.
- rdRegIn  in  5  destination register.
- mem_req  out  1  memory request, held high until ack or abort.
- mem_we  out  1  1 = write.
- mem_addr  out  32  word address, equal to {ALUResultIn[31:2],2'b00}.
- mem_be  out  4  byte enables.
- mem_wdata  out  32  lane-replicated store data.
- mem_ack  in  1  single-cycle completion strobe.
- mem_rdata  in  32  read data, valid with mem_ack.
- Stall  out  1  combinational; upstream stages and EX/MEM must hold while high.
- LoadDataOut  out  32  extended load result.
- ALUResultOut  out  32  registered ALUResultIn.
- rdRegOut  out  5  registered rdRegIn.
- RegWriteOut  out  1  registered RegWriteIn, gated by error.
- MemToRegOut  out  1  registered MemToRegIn.
- MisalignOut  out  1  one-result flag: access was misaligned.
- TimeoutOut  out  1  one-result flag: memory timed out.

Behaviour:
- Reset (async, rst_n=0):
  - FSM enters IDLE; wait counter is 0.
  - mem_req, mem_we, mem_be are 0; all registered outputs are 0; Stall is 0.
  - mem_req drops immediately, even mid-transaction.
- FSM states: IDLE, REQ, DONE.
- access = MemReadIn | MemWriteIn.
- If MemReadIn and MemWriteIn are both 1, the access is a store and the read is ignored.
- Misaligned when:
  - half with ALUResultIn[0]=1; or
  - word/reserved with ALUResultIn[1:0]!=0.
- IDLE:
  - access and aligned: Stall=1, latch address/size/data/type, go to REQ next cycle.
  - access and misaligned: no memory request, Stall=0. The output register captures the instruction with MisalignOut=1, RegWriteOut=0, LoadDataOut=0.
  - no access: Stall=0, pass-through (1-cycle latency).
- REQ:
  - mem_req=1, Stall=1; mem_addr/mem_we/mem_be/mem_wdata are stable from latched values.
  - mem_ack=1: capture mem_rdata, go to DONE.
  - Otherwise increment the counter. If the counter reaches MAX_WAIT-1 with no ack, set the timeout flag and go to DONE (REQ lasts at most MAX_WAIT cycles).
- DONE:
  - mem_req=0, Stall=0; the output register captures the result; return to IDLE.
  - Timeout case: TimeoutOut=1, RegWriteOut=0, LoadDataOut=0.
- Output register loads on every rising edge where Stall=0; it holds while Stall=1.
- MisalignOut/TimeoutOut are valid only for the result they accompany; they clear on the next load of the output register.
- Byte enables (little-endian; off = addr[1:0]):
  - byte: 1<<off.
  - half: addr[1]?1100:0011.
  - word: 1111.
- Store data: byte replicated ×4; half replicated ×2; word as-is.
- Load data:
  - byte lane selected by off, sign-extended to 32.
  - half selected by addr[1], sign-extended.
  - word unmodified.
- mem_ack while in IDLE or DONE is ignored.
- Load latency with ack in the first REQ cycle: Stall high 2 cycles; result visible after the DONE edge.
- Back-to-back memory instructions: DONE→IDLE costs one cycle, and a new access is detected in that IDLE cycle.

Test Plan:
1. Reset, then non-memory instruction (ALUResultIn=0x1234, rd=5, RegWrite=1) → Stall stays 0; next edge ALUResultOut=0x1234, rdRegOut=5, RegWriteOut=1.
2. Store byte addr 0x103, data 0x000000AB, ack after 2 REQ cycles → mem_addr=0x100, mem_be=1000, mem_wdata=0xABABABAB, mem_we=1; Stall high 3 cycles; mem_req drops the cycle after ack.
3. Load half addr 0x202, mem_rdata=0x8001_7FFF with immediate ack → LoadDataOut=0xFFFF8001; load byte addr 0x200 on same data → 0xFFFFFFFF; load word → 0x80017FFF.
4. Load word addr 0x006 → no mem_req, Stall 0, MisalignOut=1, RegWriteOut=0 at next edge; following instruction clears MisalignOut.
5. Load with mem_ack never asserted, MAX_WAIT=16 → mem_req high exactly 16 cycles, then TimeoutOut=1, RegWriteOut=0; late ack in IDLE ignored.
6. rst_n low during REQ (cycle 3 of wait) → mem_req and all outputs 0 immediately; after release a new load completes normally.
